// File: rtl/vdc_pkg.sv
// Shared definitions for the VDC video-RAM access controller.
package vdc_pkg;

    localparam int unsigned ADDR_W       = 16;
    localparam logic [15:0] ADDR16K_MASK = 16'h3FFF;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        PF,
        PF_WAIT,
        FILL,
        CP_RD,
        CP_WAIT,
        CP_WR
    } ramctl_state_t;

endpackage

// File: rtl/vdc_ramctl.sv
// VDC video-RAM sequencer: display fetches win the slot, CPU update traffic
// (R31 data, R30 fill/copy, update-address prefetch) uses the rest.
module vdc_ramctl
    import vdc_pkg::*;
#(
    parameter int unsigned ADDR_W = vdc_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ram64,
    input  logic              ua_ld,
    input  logic [ADDR_W-1:0] ua_in,
    input  logic              ba_ld,
    input  logic [ADDR_W-1:0] ba_in,
    input  logic              da_wr,
    input  logic [7:0]        da_in,
    input  logic              da_rd,
    input  logic              wc_wr,
    input  logic [7:0]        wc_in,
    input  logic              copy,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_ack,
    output logic              disp_valid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] ua_out,
    output logic [ADDR_W-1:0] ba_out,
    output logic [7:0]        wc_out,
    output logic [7:0]        da_out
);

    ramctl_state_t     state_q, state_d;
    logic [ADDR_W-1:0] ua_q, ua_d, ua_eff;
    logic [ADDR_W-1:0] ba_q, ba_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [7:0]        da_q, da_d;
    logic              inc_pend_q, inc_pend_d;
    logic              rd_iss_q, rd_iss_d;
    logic              rdv_q;
    logic              disp_ack_q, disp_valid_q;
    logic [ADDR_W-1:0] ram_addr_q, bus_addr, addr_mask;
    logic              ram_we_q, bus_we;
    logic [7:0]        ram_wdata_q, bus_wdata;
    logic              slot_free;

    assign slot_free = !disp_req;
    assign addr_mask = ram64 ? '1 : ADDR_W'(ADDR16K_MASK);
    // The R31 write advances ua one cycle after the write, folded into the prefetch read.
    assign ua_eff    = ua_q + ADDR_W'(inc_pend_q);

    always_comb begin
        state_d    = state_q;
        ua_d       = ua_eff;
        ba_d       = ba_q;
        cnt_d      = cnt_q;
        da_d       = da_q;
        inc_pend_d = 1'b0;
        rd_iss_d   = 1'b0;
        bus_addr   = disp_addr;
        bus_we     = 1'b0;
        bus_wdata  = '0;

        if (ba_ld && state_q != CP_RD) begin
            ba_d = ba_in;
        end

        case (state_q)
            IDLE: begin
                if (ua_ld) begin
                    ua_d    = ua_in;
                    state_d = PF;
                end else if (wc_wr) begin
                    cnt_d   = (wc_in == '0) ? 9'd256 : {1'b0, wc_in};
                    state_d = copy ? CP_RD : FILL;
                end else if (da_wr) begin
                    da_d    = da_in;
                    state_d = WR;
                end else if (da_rd) begin
                    ua_d    = ua_eff + 1'b1;
                    state_d = PF;
                end
            end
            WR: if (slot_free) begin
                bus_addr   = ua_eff;
                bus_we     = 1'b1;
                bus_wdata  = da_q;
                inc_pend_d = 1'b1;
                state_d    = PF;
            end
            PF: if (slot_free) begin
                bus_addr = ua_eff;
                rd_iss_d = 1'b1;
                state_d  = PF_WAIT;
            end
            PF_WAIT: if (rdv_q) begin
                da_d    = ram_rdata;
                state_d = IDLE;
            end
            FILL, CP_WR: if (slot_free) begin
                bus_addr  = ua_eff;
                bus_we    = 1'b1;
                bus_wdata = da_q;
                ua_d      = ua_eff + 1'b1;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == 9'd1) begin
                    state_d = IDLE;
                end else if (state_q == CP_WR) begin
                    state_d = CP_RD;
                end
            end
            CP_RD: if (slot_free) begin
                bus_addr = ba_q;
                ba_d     = ba_q + 1'b1;
                rd_iss_d = 1'b1;
                state_d  = CP_WAIT;
            end
            CP_WAIT: if (rdv_q) begin
                da_d    = ram_rdata;
                state_d = CP_WR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            ua_q         <= '0;
            ba_q         <= '0;
            cnt_q        <= '0;
            da_q         <= '0;
            inc_pend_q   <= 1'b0;
            rd_iss_q     <= 1'b0;
            rdv_q        <= 1'b0;
            disp_ack_q   <= 1'b0;
            disp_valid_q <= 1'b0;
            ram_addr_q   <= '0;
            ram_we_q     <= 1'b0;
            ram_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            ua_q         <= ua_d;
            ba_q         <= ba_d;
            cnt_q        <= cnt_d;
            da_q         <= da_d;
            inc_pend_q   <= inc_pend_d;
            rd_iss_q     <= rd_iss_d;
            rdv_q        <= rd_iss_q;
            disp_ack_q   <= disp_req;
            disp_valid_q <= disp_ack_q;
            ram_addr_q   <= bus_addr & addr_mask;
            ram_we_q     <= bus_we;
            ram_wdata_q  <= bus_wdata;
        end
    end

    assign disp_ack   = disp_ack_q;
    assign disp_valid = disp_valid_q;
    assign ram_addr   = ram_addr_q;
    assign ram_we     = ram_we_q;
    assign ram_wdata  = ram_wdata_q;
    assign busy       = (state_q != IDLE);
    assign ua_out     = ua_q;
    assign ba_out     = ba_q;
    assign wc_out     = cnt_q[7:0];
    assign da_out     = da_q;

endmodule

// File: tb/tb_vdc_ramctl.sv
// Bench for vdc_ramctl: RAM model plus a scoreboard of expected RAM writes.
module tb_vdc_ramctl;

    logic        clk = 1'b0;
    logic        reset_n, ram64, ua_ld, ba_ld, da_wr, da_rd, wc_wr, copy, disp_req;
    logic [15:0] ua_in, ba_in, disp_addr;
    logic [7:0]  da_in, wc_in;
    logic        disp_ack, disp_valid, ram_we, busy;
    logic [15:0] ram_addr, ua_out, ba_out;
    logic [7:0]  ram_wdata, ram_rdata, wc_out, da_out;

    logic [7:0]  mem [0:65535];
    logic        pre_we;
    logic [15:0] pre_a;
    logic [7:0]  pre_d;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;
    wr_t exp_q[$];
    logic sb_on;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    vdc_ramctl #(.ADDR_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .ram64(ram64),
        .ua_ld(ua_ld), .ua_in(ua_in), .ba_ld(ba_ld), .ba_in(ba_in),
        .da_wr(da_wr), .da_in(da_in), .da_rd(da_rd),
        .wc_wr(wc_wr), .wc_in(wc_in), .copy(copy),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_ack(disp_ack), .disp_valid(disp_valid),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy),
        .ua_out(ua_out), .ba_out(ba_out), .wc_out(wc_out), .da_out(da_out)
    );

    // Synchronous single-port RAM: data valid the cycle after its address.
    always @(posedge clk) begin
        if (pre_we) mem[pre_a] <= pre_d;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && sb_on && ram_we) begin
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", {ram_addr, ram_wdata}, 32'h0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", ram_addr, e.a);
                chk("wr_data", ram_wdata, e.d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        pre_a = a; pre_d = d; pre_we = 1'b1;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
        wr_t e;
        e.a = a; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input int unsigned lim);
        int unsigned n = 0;
        while (busy && n < lim) begin
            tick();
            n++;
        end
        if (busy) chk("idle_timeout", busy, 1'b0);
    endtask

    task automatic load_ua(input logic [15:0] a);
        ua_in = a; ua_ld = 1'b1;
        tick();
        ua_ld = 1'b0;
        wait_idle(20);
    endtask

    initial begin
        reset_n = 1'b0; ram64 = 1'b1; ua_ld = 0; ba_ld = 0; da_wr = 0; da_rd = 0;
        wc_wr = 0; copy = 0; disp_req = 0; ua_in = '0; ba_in = '0; da_in = '0;
        wc_in = '0; disp_addr = 16'h0ABC; pre_we = 0; pre_a = '0; pre_d = '0; sb_on = 1'b1;

        poke(16'h1000, 8'h5A); poke(16'h1001, 8'h20);
        poke(16'h2000, 8'h11); poke(16'h2001, 8'h22);
        poke(16'h4000, 8'h66); poke(16'h0000, 8'h9C);
        poke(16'h0001, 8'hB1); poke(16'h7000, 8'hC5);
        chk("rst_busy", busy, 0);    chk("rst_we", ram_we, 0);
        chk("rst_addr", ram_addr, 0); chk("rst_ua", ua_out, 0);
        chk("rst_da", da_out, 0);    chk("rst_ack", disp_ack, 0);
        reset_n = 1'b1;
        tick();

        // prefetch after update-address load
        ua_in = 16'h1000; ua_ld = 1'b1;
        tick(); ua_ld = 1'b0;
        tick();
        chk("pf_addr", ram_addr, 16'h1000); chk("pf_we", ram_we, 0); chk("pf_busy1", busy, 1);
        tick(); chk("pf_busy2", busy, 1);
        tick(); chk("pf_da", da_out, 8'h5A); chk("pf_idle", busy, 0);

        // R31 write then fill of 3
        push_wr(16'h1000, 8'h20);
        da_in = 8'h20; da_wr = 1'b1;
        tick(); da_wr = 1'b0;
        tick();
        chk("wr_we", ram_we, 1); chk("wr_ua_c1", ua_out, 16'h1000);
        tick();
        chk("wr_ua_c2", ua_out, 16'h1001); chk("wr_pf_addr", ram_addr, 16'h1001); chk("wr_pf_we", ram_we, 0);
        tick(); chk("wr_busy3", busy, 1);
        tick(); chk("wr_idle4", busy, 0); chk("wr_da", da_out, 8'h20);

        for (int i = 1; i <= 3; i++) push_wr(16'(16'h1000 + i), 8'h20);
        wc_in = 8'd3; copy = 1'b0; wc_wr = 1'b1;
        tick(); wc_wr = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk("fill_we", ram_we, 1);
            chk("fill_wc", wc_out, 32'(3 - c));
        end
        chk("fill_idle", busy, 0); chk("fill_ua", ua_out, 16'h1004);

        // copy of 2
        ba_in = 16'h2000; ba_ld = 1'b1;
        tick(); ba_ld = 1'b0;
        load_ua(16'h3000);
        push_wr(16'h3000, 8'h11); push_wr(16'h3001, 8'h22);
        wc_in = 8'd2; copy = 1'b1; wc_wr = 1'b1;
        tick(); wc_wr = 1'b0; copy = 1'b0;
        wait_idle(40);
        chk("cp_ba", ba_out, 16'h2002); chk("cp_ua", ua_out, 16'h3002);
        chk("cp_wc", wc_out, 0);       chk("cp_da", da_out, 8'h22);
        tick();
        chk("cp_mem0", mem[16'h3000], 8'h11); chk("cp_mem1", mem[16'h3001], 8'h22);

        // display holds the slot for 5 cycles during a fill of 4
        load_ua(16'h4000);
        for (int i = 0; i < 4; i++) push_wr(16'(16'h4000 + i), 8'h66);
        wc_in = 8'd4; wc_wr = 1'b1;
        tick(); wc_wr = 1'b0; disp_req = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 5) disp_req = 1'b0;
            chk("dsp_we", ram_we, 32'(c >= 6));
            chk("dsp_ack", disp_ack, 32'(c <= 5));
            chk("dsp_valid", disp_valid, 32'(c >= 2 && c <= 6));
            chk("dsp_busy", busy, 32'(c < 9));
            if (c <= 5) chk("dsp_addr", ram_addr, 16'h0ABC);
        end
        chk("dsp_ua", ua_out, 16'h4004);

        // 16k mask and 16-bit wrap
        ram64 = 1'b0;
        load_ua(16'hFFFF);
        push_wr(16'h3FFF, 8'h7E);
        da_in = 8'h7E; da_wr = 1'b1;
        tick(); da_wr = 1'b0;
        tick(); chk("m16_addr", ram_addr, 16'h3FFF); chk("m16_we", ram_we, 1);
        wait_idle(20);
        chk("m16_ua", ua_out, 16'h0000); chk("m16_da", da_out, 8'h9C);
        ram64 = 1'b1;

        // R31 read: CPU sees old byte, ua advances, new prefetch
        da_rd = 1'b1;
        tick(); da_rd = 1'b0;
        tick(); chk("rd_da_old", da_out, 8'h9C); chk("rd_ua", ua_out, 16'h0001);
        wait_idle(20);
        chk("rd_da_new", da_out, 8'hB1);

        // simultaneous strobes: ua_ld wins, the rest dropped
        ua_in = 16'h7000; wc_in = 8'd5; da_in = 8'hEE;
        ua_ld = 1'b1; wc_wr = 1'b1; da_wr = 1'b1; da_rd = 1'b1;
        tick(); ua_ld = 0; wc_wr = 0; da_wr = 0; da_rd = 0;
        wait_idle(20);
        chk("pri_ua", ua_out, 16'h7000); chk("pri_wc", wc_out, 0); chk("pri_da", da_out, 8'hC5);
        tick(); chk("pri_still_idle", busy, 0);

        // fill of 256 aborted by reset; strobes while busy
        load_ua(16'h6000);
        sb_on = 1'b0;
        wc_in = 8'd0; wc_wr = 1'b1;
        tick(); wc_wr = 1'b0;
        for (int c = 1; c <= 6; c++) tick();
        ua_in = 16'h5555; ua_ld = 1'b1; ba_in = 16'h1234; ba_ld = 1'b1;
        tick(); ua_ld = 1'b0; ba_ld = 1'b0;
        tick(); tick(); tick();
        chk("f256_wc", wc_out, 8'd246); chk("f256_ua", ua_out, 16'h600A);
        chk("f256_ba", ba_out, 16'h1234); chk("f256_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("ar_busy", busy, 0); chk("ar_we", ram_we, 0); chk("ar_ua", ua_out, 0);
        chk("ar_wc", wc_out, 0); chk("ar_ba", ba_out, 0);
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("post_rst_we", ram_we, 0);
        end

        chk("wr_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
